sd_adc_rx: RTL and testbench

SD_ADC_RX -- requirements
Module: sd_adc_rx

---
 rtl/sd_adc_rx_pkg.sv | 12 +
 rtl/sd_adc_rx_if.sv | 12 +
 rtl/sd_adc_rx_decim.sv | 53 +++++
 rtl/sd_adc_rx.sv | 86 ++++++++
 tb/tb_sd_adc_rx.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/sd_adc_rx_pkg.sv
// Shared constants for the sigma-delta ADC receiver.
// Sample width, decimation range and the mid-scale code.
package sd_adc_pkg;

    localparam int SAMPLE_W       = 8;
    localparam int DECIM_LOG2_DEF = 13;
    localparam int DECIM_LOG2_MIN = 8;
    localparam int DECIM_LOG2_MAX = 16;

    localparam logic [SAMPLE_W-1:0] MID_SCALE = 8'd128;

endpackage

// File: rtl/sd_adc_rx_if.sv
// Sample strobe bus from the decimator to the output handshake.
// stb is a one-cycle pulse qualifying data.
interface sd_adc_rx_if;
    import sd_adc_pkg::*;

    logic [SAMPLE_W-1:0] data;
    logic                stb;

    modport master (output data, output stb);
    modport slave  (input  data, input  stb);

endinterface

// File: rtl/sd_adc_rx_decim.sv
// Window counter, ones accumulator and saturation for the modulator bitstream.
// Emits one strobe in the last cycle of every 2^DECIM_LOG2 window.
module sd_decimator
    import sd_adc_pkg::*;
#(
    parameter int DECIM_LOG2 = DECIM_LOG2_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic bit_i,
    sd_adc_rx_if.master smp
);

    localparam int W = DECIM_LOG2;

    if (DECIM_LOG2 < DECIM_LOG2_MIN || DECIM_LOG2 > DECIM_LOG2_MAX) begin : g_bad_width
        $error("sd_decimator: DECIM_LOG2 out of range");
    end

    logic [W-1:0] win_q, win_d;
    logic [W:0]   acc_q, acc_d;
    logic [W:0]   result;
    logic         last;

    always_comb begin
        result = acc_q + {{W{1'b0}}, bit_i};
        last   = en_i & (&win_q);
        win_d  = '0;
        acc_d  = '0;
        if (en_i) begin
            win_d = win_q + {{(W-1){1'b0}}, 1'b1};
            acc_d = last ? '0 : result;
        end
    end

    // Only an all-ones window reaches 2^W; clamp it to full scale.
    always_comb begin
        smp.stb  = last;
        smp.data = result[W] ? '1 : result[W-1 -: SAMPLE_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
            acc_q <= '0;
        end else begin
            win_q <= win_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/sd_adc_rx.sv
// Sigma-delta ADC receiver: comparator sync, RC feedback, decimation
// and a valid/ack sample register with sticky overrun.
module sd_adc_rx
    import sd_adc_pkg::*;
#(
    parameter int DECIM_LOG2 = DECIM_LOG2_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                comp_in,
    output logic                fb_out,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_valid,
    input  logic                sample_ack,
    output logic                overrun,
    input  logic                overrun_clr
);

    logic                s1_q;
    logic                comp_q;
    logic [SAMPLE_W-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                ovr_q, ovr_d;

    sd_adc_rx_if smp ();

    sd_decimator #(
        .DECIM_LOG2 (DECIM_LOG2)
    ) u_decim (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (en),
        .bit_i (comp_q),
        .smp   (smp.master)
    );

    // Feedback runs even while disabled so the integrator stays balanced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            comp_q <= 1'b0;
        end else begin
            s1_q   <= comp_in;
            comp_q <= s1_q;
        end
    end

    assign fb_out = comp_q;

    // A new sample beats ack; set of overrun beats its clear.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (overrun_clr) begin
            ovr_d = 1'b0;
        end
        if (smp.stb) begin
            data_d  = smp.data;
            valid_d = 1'b1;
            if (valid_q && !sample_ack) begin
                ovr_d = 1'b1;
            end
        end else if (sample_ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_sd_adc_rx.sv
// Directed bench for sd_adc_rx with a 256-clock window.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_sd_adc_rx;
    import sd_adc_pkg::*;

    localparam int DL = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic comp_in;
    logic fb_out;
    logic sample_ack;
    logic overrun;
    logic overrun_clr;

    sd_adc_rx_if mon ();

    always #5 clk = ~clk;

    sd_adc_rx #(
        .DECIM_LOG2 (DL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .comp_in      (comp_in),
        .fb_out       (fb_out),
        .sample_data  (mon.data),
        .sample_valid (mon.stb),
        .sample_ack   (sample_ack),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit tog = 1'b0;
    bit chk_fb = 1'b0;
    logic h1, h2;
    int n;

    // Two-clock delay line of comp_in: the expected fb_out.
    always @(posedge clk) begin
        h2 <= h1;
        h1 <= comp_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk_fb) chk("fb_delay2", {31'b0, fb_out}, {31'b0, h2});
        if (tog) comp_in = ~comp_in;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic wait_sample(input int bound, output int cnt);
        cnt = 0;
        for (int i = 1; i <= bound && cnt == 0; i++) begin
            tick();
            if (mon.stb === 1'b1) cnt = i;
        end
        if (cnt == 0) chk("sample_timeout", {31'b0, mon.stb}, 32'd1);
    endtask

    task automatic ack();
        sample_ack = 1'b1;
        tick();
        sample_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        comp_in = 1'b0;
        sample_ack = 1'b0;
        overrun_clr = 1'b0;
        ticks(3);
        chk("rst_data", {24'b0, mon.data}, 32'd0);
        chk("rst_valid", {31'b0, mon.stb}, 32'd0);
        chk("rst_ovr", {31'b0, overrun}, 32'd0);
        chk("rst_fb", {31'b0, fb_out}, 32'd0);

        // Constant ones: two reset zeros in the first window.
        comp_in = 1'b1;
        en = 1'b1;
        rst_n = 1'b1;
        wait_sample(300, n);
        chk("first_latency", n, 32'd256);
        chk("first_254", {24'b0, mon.data}, 32'd254);
        ack();
        wait_sample(300, n);
        chk("period_256", n, 32'd255);
        chk("sat_255", {24'b0, mon.data}, 32'd255);

        // Leave 255 unacked; next window holds only two pipelined ones.
        comp_in = 1'b0;
        ticks(255);
        chk("hold_valid", {31'b0, mon.stb}, 32'd1);
        chk("no_ovr_yet", {31'b0, overrun}, 32'd0);
        tick();
        chk("ovr_set", {31'b0, overrun}, 32'd1);
        chk("ovr_data", {24'b0, mon.data}, 32'd2);
        chk("ovr_valid", {31'b0, mon.stb}, 32'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ovr_clr", {31'b0, overrun}, 32'd0);
        ack();
        chk("ack_clears", {31'b0, mon.stb}, 32'd0);
        ack();
        chk("ack_idle", {31'b0, mon.stb}, 32'd0);

        chk_fb = 1'b1;
        wait_sample(300, n);
        chk("zero_data", {24'b0, mon.data}, 32'd0);
        chk("zero_fb", {31'b0, fb_out}, 32'd0);
        chk_fb = 1'b0;
        ack();

        // Alternating bits: discard the mixed window first.
        tog = 1'b1;
        wait_sample(300, n);
        ack();
        chk_fb = 1'b1;
        wait_sample(300, n);
        chk("toggle_a", {24'b0, mon.data}, {24'b0, MID_SCALE});
        ack();
        wait_sample(300, n);
        chk("toggle_b", {24'b0, mon.data}, {24'b0, MID_SCALE});
        chk_fb = 1'b0;

        // Ack lands on the edge that loads the next sample.
        ticks(255);
        sample_ack = 1'b1;
        tick();
        sample_ack = 1'b0;
        chk("ack_coinc_valid", {31'b0, mon.stb}, 32'd1);
        chk("ack_coinc_ovr", {31'b0, overrun}, 32'd0);
        chk("ack_coinc_data", {24'b0, mon.data}, {24'b0, MID_SCALE});
        ack();

        // Reset at win_cnt=100 of a window.
        tog = 1'b0;
        comp_in = 1'b1;
        wait_sample(300, n);
        ticks(100);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", {24'b0, mon.data}, 32'd0);
        chk("mid_rst_valid", {31'b0, mon.stb}, 32'd0);
        chk("mid_rst_ovr", {31'b0, overrun}, 32'd0);
        chk("mid_rst_fb", {31'b0, fb_out}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        // Cycles counted include the one in which reset is released.
        n = 0;
        for (int i = 1; i <= 400 && n == 0; i++) begin
            @(posedge clk);
            #1;
            if (mon.stb === 1'b1) n = i + 1;
        end
        if (n == 0) chk("rst_timeout", {31'b0, mon.stb}, 32'd1);
        chk("rst_to_valid", n, 32'd257);
        chk("rst_first_254", {24'b0, mon.data}, 32'd254);

        // Enable dropped mid-window: partial window discarded.
        ticks(50);
        en = 1'b0;
        ticks(3);
        chk("en_hold_valid", {31'b0, mon.stb}, 32'd1);
        chk("en_hold_data", {24'b0, mon.data}, 32'd254);
        ack();
        chk("en_ack", {31'b0, mon.stb}, 32'd0);
        en = 1'b1;
        wait_sample(400, n);
        chk("en_restart", n, 32'd256);
        chk("en_full_255", {24'b0, mon.data}, 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
